reg_file_wb: RTL

//  Architectural register file and write-back stage for the 8-bit core. Sits directly upstream
//  of the ALU: read ports A/B drive the ALU A and B inputs.
//  It also sits downstream of the ALU: the ALU Out result, or a data-memory load, is written

---
 rtl/reg_file_wb.sv | 62 ++++++
 1 files changed

// File: rtl/reg_file_wb.sv
// Register file with ALU/memory write-back, sticky zero flag and write-back status.
// Optional build macro REG_BYPASS_EN adds same-cycle write-through forwarding to both read ports.
module reg_file_wb #(
    parameter  int W     = 8,
    parameter  int NREGS = 8,
    localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [AW-1:0] RaddrA,
    input  logic [AW-1:0] RaddrB,
    output logic [W-1:0]  DataOutA,
    output logic [W-1:0]  DataOutB,
    input  logic          WriteEn,
    input  logic          WriteSel,
    input  logic [AW-1:0] Waddr,
    input  logic [W-1:0]  AluResult,
    input  logic [W-1:0]  MemData,
    input  logic          FlagWe,
    input  logic          ZeroIn,
    output logic          ZeroFlag,
    output logic          WbValid,
    output logic [AW-1:0] WbAddr
);

    logic [W-1:0] regs [NREGS];
    logic [W-1:0] wdata;

    // Addresses only escape the array when NREGS is not a power of two.
    function automatic logic in_range(input logic [AW-1:0] addr);
        return int'(addr) < NREGS;
    endfunction

    assign wdata = WriteSel ? MemData : AluResult;

    // NOTE: every output gets a default first, so no path through this block can infer a latch.
    always_comb begin
        DataOutA = in_range(RaddrA) ? regs[RaddrA] : '0;
        DataOutB = in_range(RaddrB) ? regs[RaddrB] : '0;
`ifdef REG_BYPASS_EN
        if (WriteEn && in_range(Waddr) && (RaddrA == Waddr)) DataOutA = wdata;
        if (WriteEn && in_range(Waddr) && (RaddrB == Waddr)) DataOutB = wdata;
`endif
    end

    // NOTE: the register array is reset too, because architectural state must read 0 after
    // reset; non-blocking assignments keep every update sampled on the same edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            ZeroFlag <= 1'b0;
            WbValid  <= 1'b0;
            WbAddr   <= '0;
        end else begin
            if (WriteEn && in_range(Waddr)) regs[Waddr] <= wdata;
            if (FlagWe) ZeroFlag <= ZeroIn;
            WbValid <= WriteEn;
            WbAddr  <= Waddr;
        end
    end

endmodule
